// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin sharing of the vga_adapter pixel port between NREQ producers.
// Define CLEAR_SWEEP_EN to build the full-screen clear sweep; otherwise only arbitration is built.
module vga_plot_arbiter #(
  parameter int NREQ = 3,
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int CW   = 3,
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*XW-1:0] req_x,
  input  logic [NREQ*YW-1:0] req_y,
  input  logic [NREQ*CW-1:0] req_colour,
  output logic [NREQ-1:0]    req_ready,
  input  logic               clear_req,
  input  logic [CW-1:0]      clear_colour,
  output logic               clear_busy,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic [CW-1:0]      colour,
  output logic               plot,
  output logic [1:0]         grant_id
);
`ifdef CLEAR_SWEEP_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif
  typedef enum logic {ARB, SWEEP} state_t;
  state_t state, state_n;
  logic [1:0] ptr, win;
  logic [2:0] idx;
  logic found, take_clear, xfer, last, in_range;
  logic [XW-1:0] sx, wx;
  logic [YW-1:0] sy, wy;
  logic [CW-1:0] ccol, wc;
  // Walk from the farthest candidate back to ptr so the nearest valid one wins.
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = 3'(ptr) + 3'(k);
      idx = (idx >= 3'(NREQ)) ? idx - 3'(NREQ) : idx;
      win = req_valid[idx[1:0]] ? idx[1:0] : win;
      found = found | req_valid[idx[1:0]];
    end
  end
  assign wx = req_x[int'(win)*XW +: XW];
  assign wy = req_y[int'(win)*YW +: YW];
  assign wc = req_colour[int'(win)*CW +: CW];
  assign in_range = (wx <= XW'(XMAX)) && (wy <= YW'(YMAX));
  assign take_clear = SW && state == ARB && clear_req;
  assign xfer = reset && state == ARB && !take_clear && found;
  assign req_ready = xfer ? NREQ'(1) << win : '0;
  assign last = (sx == XW'(XMAX)) && (sy == YW'(YMAX));
  assign clear_busy = state == SWEEP;
  always_comb begin
    state_n = ARB;
    if (SW) state_n = (state == ARB) ? (clear_req ? SWEEP : ARB) : (last ? ARB : SWEEP);
  end
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state <= ARB;
      ptr <= '0;
      x <= '0;
      y <= '0;
      colour <= '0;
      plot <= 1'b0;
      grant_id <= '0;
      sx <= '0;
      sy <= '0;
      ccol <= '0;
    end else begin
      state <= state_n;
      plot <= 1'b0;
      if (state == SWEEP) begin
        x <= sx;
        y <= sy;
        colour <= ccol;
        plot <= 1'b1;
        sx <= (sx == XW'(XMAX)) ? '0 : sx + 1'b1;
        sy <= (sx != XW'(XMAX)) ? sy : (sy == YW'(YMAX)) ? '0 : sy + 1'b1;
      end else if (take_clear) begin
        ccol <= clear_colour;
        sx <= '0;
        sy <= '0;
      end else if (xfer) begin
        ptr <= (win == 2'(NREQ - 1)) ? 2'd0 : win + 2'd1;
        grant_id <= win;
        plot <= in_range;
        x <= in_range ? wx : x;
        y <= in_range ? wy : y;
        colour <= in_range ? wc : colour;
      end
    end
  end
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: table-driven arbitration vectors with an output scoreboard,
// plus hand-written reset, clear and sweep sequences.
module tb_vga_plot_arbiter;
  logic CLOCK_50 = 1'b0;
  logic reset;
  logic [2:0] req_valid;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0] req_colour;
  logic [2:0] req_ready;
  logic clear_req;
  logic [2:0] clear_colour;
  logic clear_busy;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic plot;
  logic [1:0] grant_id;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic [1:0] gid;
  } exp_t;
  typedef struct {
    logic [2:0] v;
    logic [2:0] ready;
    logic plot;
    logic [7:0] xs[3];
    logic [6:0] ys[3];
    logic [2:0] cs[3];
  } vec_t;
  exp_t sb[$];
  vec_t tbl[15];
  vga_plot_arbiter dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .req_ready(req_ready), .clear_req(clear_req),
    .clear_colour(clear_colour), .clear_busy(clear_busy), .x(x), .y(y), .colour(colour),
    .plot(plot), .grant_id(grant_id)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic set_row(input int r);
    req_valid = tbl[r].v;
    for (int i = 0; i < 3; i++) begin
      req_x[i*8 +: 8] = tbl[r].xs[i];
      req_y[i*7 +: 7] = tbl[r].ys[i];
      req_colour[i*3 +: 3] = tbl[r].cs[i];
    end
  endtask
  // Called just after a negedge with inputs set; ends on the following negedge.
  task automatic cycle(input string nm, input logic [2:0] er, input logic ep);
    exp_t e;
    int w;
    #1;
    chk({nm, "_ready"}, req_ready, er);
    w = er[1] ? 1 : er[2] ? 2 : 0;
    e.plot = ep;
    e.x = req_x[w*8 +: 8];
    e.y = req_y[w*7 +: 7];
    e.c = req_colour[w*3 +: 3];
    e.gid = 2'(w);
    sb.push_back(e);
    @(posedge CLOCK_50);
    #1;
    e = sb.pop_front();
    chk({nm, "_plot"}, plot, e.plot);
    if (e.plot) begin
      chk({nm, "_x"}, x, e.x);
      chk({nm, "_y"}, y, e.y);
      chk({nm, "_colour"}, colour, e.c);
      chk({nm, "_gid"}, grant_id, e.gid);
    end
    @(negedge CLOCK_50);
  endtask
  initial begin
    logic [2:0] rv[15] = '{3'b000, 3'b010, 3'b100, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
                           3'b111, 3'b001, 3'b101, 3'b110, 3'b001, 3'b111, 3'b000};
    logic [2:0] rr[15] = '{3'b000, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010,
                           3'b100, 3'b001, 3'b100, 3'b010, 3'b001, 3'b010, 3'b000};
    logic rp[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int r = 0; r < 15; r++) begin
      tbl[r].v = rv[r];
      tbl[r].ready = rr[r];
      tbl[r].plot = rp[r];
      for (int i = 0; i < 3; i++) begin
        tbl[r].xs[i] = 8'(r*9 + i*3);
        tbl[r].ys[i] = 7'(r*5 + i);
        tbl[r].cs[i] = 3'(r + i);
      end
    end
    tbl[1].xs[1] = 8'd10; tbl[1].ys[1] = 7'd20; tbl[1].cs[1] = 3'b111;
    tbl[9].xs[0] = 8'd160; tbl[9].ys[0] = 7'd5;
    tbl[12].ys[0] = 7'd120;
    reset = 1'b0;
    clear_req = 1'b0;
    clear_colour = 3'b000;
    req_valid = 3'b111;
    req_x = '0;
    req_y = '0;
    req_colour = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      chk("rst_ready", req_ready, 0);
    end
    reset = 1'b1;
    req_valid = 3'b000;
    #1;
    chk("rst_plot", plot, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_colour", colour, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", clear_busy, 0);
    for (int r = 0; r < 15; r++) begin
      set_row(r);
      cycle($sformatf("row%0d", r), tbl[r].ready, tbl[r].plot);
    end
    // Reset in the middle of traffic: pointer back to 0, ready held low.
    set_row(5);
    reset = 1'b0;
    #1;
    chk("midrst_ready", req_ready, 0);
    @(posedge CLOCK_50);
    #1;
    chk("midrst_plot", plot, 0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    cycle("post_rst0", 3'b001, 1'b1);
    cycle("post_rst1", 3'b010, 1'b1);
    cycle("post_rst2", 3'b100, 1'b1);
    req_valid = 3'b100;
    req_x[16 +: 8] = 8'd5;
    req_y[14 +: 7] = 7'd6;
    req_colour[6 +: 3] = 3'd2;
`ifndef CLEAR_SWEEP_EN
    clear_req = 1'b1;
    clear_colour = 3'b101;
    cycle("clr_ignored", 3'b100, 1'b1);
    chk("clr_busy", clear_busy, 0);
    clear_req = 1'b0;
`else
    begin
      int bad_r, bad_p, i;
      clear_req = 1'b1;
      clear_colour = 3'b001;
      #1;
      chk("clr_ready", req_ready, 0);
      @(negedge CLOCK_50);
      clear_req = 1'b0;
      clear_colour = 3'b110;
      bad_r = 0;
      bad_p = 0;
      for (int n = 0; n < 19200; n++) begin
        if (req_ready !== 3'b000 || clear_busy !== 1'b1) bad_r++;
        @(posedge CLOCK_50);
        #1;
        if (!(plot === 1'b1 && x === 8'(n % 160) && y === 7'(n / 160) && colour === 3'b001)) bad_p++;
        @(negedge CLOCK_50);
      end
      chk("sweep_ready_busy", bad_r, 0);
      chk("sweep_pixels", bad_p, 0);
      chk("sweep_end_busy", clear_busy, 0);
      cycle("after_sweep", 3'b100, 1'b1);
      req_valid = 3'b000;
      clear_req = 1'b1;
      @(negedge CLOCK_50);
      clear_req = 1'b0;
      i = 0;
      while (i < 20000 && !(plot === 1'b1 && x === 8'd40 && y === 7'd50)) begin
        @(negedge CLOCK_50);
        i++;
      end
      chk("reach_40_50", (i < 20000), 1);
      reset = 1'b0;
      @(posedge CLOCK_50);
      #1;
      chk("abort_busy", clear_busy, 0);
      chk("abort_plot", plot, 0);
      @(negedge CLOCK_50);
      reset = 1'b1;
      set_row(5);
      cycle("abort_g0", 3'b001, 1'b1);
      cycle("abort_g1", 3'b010, 1'b1);
      cycle("abort_g2", 3'b100, 1'b1);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
